// File: rtl/click_pkg.sv
// Shared state codes, gesture event codes and event payload for the click decoder.
package click_pkg;

    localparam int unsigned EV_TYPE_W = 3;
    localparam int unsigned CLICK_W   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_HELD      = 2'd1;
    localparam state_t ST_GAP       = 2'd2;
    localparam state_t ST_LONG_WAIT = 2'd3;

    localparam logic [EV_TYPE_W-1:0] EV_NONE   = 3'd0;
    localparam logic [EV_TYPE_W-1:0] EV_SINGLE = 3'd1;
    localparam logic [EV_TYPE_W-1:0] EV_DOUBLE = 3'd2;
    localparam logic [EV_TYPE_W-1:0] EV_TRIPLE = 3'd3;
    localparam logic [EV_TYPE_W-1:0] EV_LONG   = 3'd4;

    typedef struct packed {
        logic                 valid;
        logic [EV_TYPE_W-1:0] code;
    } gesture_event_t;

endpackage

// File: rtl/click_decoder_timer.sv
// Saturating up-counter with synchronous clear/enable and an equality hit against a target.
module gesture_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             hit_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats enable; the count holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_c = (cnt_q == target);

endmodule

// File: rtl/click_decoder.sv
// Classifies debounced button presses into single/double/triple/long gestures,
// emitting one registered one-cycle event per gesture.
module click_decoder
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 12_500_000,
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 press,
    input  logic                 level,
    output logic                 event_valid,
    output logic [EV_TYPE_W-1:0] event_type,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [CLICK_W-1:0]   count_q, count_d;
    gesture_event_t       ev_q, ev_d;
    logic                 busy_q, busy_d;

    logic                 tmr_clr_c;
    logic                 tmr_en_c;
    logic [CNT_W-1:0]     tmr_target_c;
    logic                 tmr_hit_c;

    // The gap window applies only while released; every other state measures hold time.
    assign tmr_target_c = (state_q == ST_GAP) ? CNT_W'(WINDOW_CYCLES - 1)
                                              : CNT_W'(LONG_CYCLES - 1);

    gesture_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_c),
        .en     (tmr_en_c),
        .target (tmr_target_c),
        .hit_c  (tmr_hit_c)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ev_d      = '0;
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    count_d   = CLICK_W'(1);
                    tmr_clr_c = 1'b1;
                    state_d   = ST_HELD;
                end
            end

            ST_HELD: begin
                if (!level) begin
                    tmr_clr_c = 1'b1;
                    state_d   = ST_GAP;
                end else if (tmr_hit_c) begin
                    ev_d.valid = 1'b1;
                    ev_d.code  = (count_q == CLICK_W'(1)) ? EV_LONG : EV_TYPE_W'(count_q);
                    tmr_clr_c  = 1'b1;
                    state_d    = ST_LONG_WAIT;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            // A press on the expiry cycle continues the gesture rather than closing it.
            ST_GAP: begin
                if (press) begin
                    tmr_clr_c = 1'b1;
                    if (count_q == CLICK_W'(2)) begin
                        ev_d.valid = 1'b1;
                        ev_d.code  = EV_TRIPLE;
                        state_d    = ST_LONG_WAIT;
                    end else begin
                        count_d = count_q + CLICK_W'(1);
                        state_d = ST_HELD;
                    end
                end else if (tmr_hit_c) begin
                    ev_d.valid = 1'b1;
                    ev_d.code  = EV_TYPE_W'(count_q);
                    count_d    = '0;
                    tmr_clr_c  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            ST_LONG_WAIT: begin
                if (!level) begin
                    count_d   = '0;
                    tmr_clr_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                count_d   = '0;
                tmr_clr_c = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ev_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ev_q    <= ev_d;
            busy_q  <= busy_d;
        end
    end

    assign event_valid = ev_q.valid;
    assign event_type  = ev_q.code;
    assign busy        = busy_q;

endmodule

// File: tb/tb_click_decoder.sv
// Directed self-checking bench for click_decoder with an 8-cycle window and 16-cycle long press.
module tb_click_decoder;

    localparam int unsigned WIN  = 8;
    localparam int unsigned LONG = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press;
    logic       level;
    logic       event_valid;
    logic [2:0] event_type;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ev_cyc[$];
    int ev_type[$];
    int b2b       = 0;
    int bad_idle  = 0;
    logic prev_valid = 1'b0;
    int r, r2, p3, e0;

    click_decoder #(
        .WINDOW_CYCLES (WIN),
        .LONG_CYCLES   (LONG),
        .CNT_W         (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press       (press),
        .level       (level),
        .event_valid (event_valid),
        .event_type  (event_type),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every event with the index of the edge that produced it.
    always @(negedge clk) begin
        if (event_valid) begin
            ev_cyc.push_back(cyc);
            ev_type.push_back(int'(event_type));
            if (prev_valid) b2b++;
        end else if (event_type != 3'd0) begin
            bad_idle++;
        end
        prev_valid = event_valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic p, input logic l);
        press = p;
        level = l;
        @(posedge clk);
        #1;
        press = 1'b0;
    endtask

    function automatic int first_cyc();
        return (ev_cyc.size() > 0) ? ev_cyc[0] : -1;
    endfunction

    function automatic int first_type();
        return (ev_type.size() > 0) ? ev_type[0] : -1;
    endfunction

    task automatic clear_log();
        ev_cyc.delete();
        ev_type.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        press = 1'b0;
        level = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(event_valid), 0);
        chk("rst_type",  int'(event_type), 0);
        chk("rst_busy",  int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0);

        // Single click
        clear_log();
        tick(1'b1, 1'b1);
        chk("single_busy_held", int'(busy), 1);
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        r = cyc;
        repeat (7) tick(1'b0, 1'b0);
        chk("single_busy_gap", int'(busy), 1);
        chk("single_no_early", int'(event_valid), 0);
        tick(1'b0, 1'b0);
        chk("single_valid", int'(event_valid), 1);
        chk("single_type",  int'(event_type), 1);
        chk("single_busy_drop", int'(busy), 0);
        tick(1'b0, 1'b0);
        chk("single_pulse_end", int'(event_valid), 0);
        repeat (4) tick(1'b0, 1'b0);
        chk("single_count", ev_cyc.size(), 1);
        chk("single_latency", first_cyc() - r, 8);

        // Double click with a 4-cycle gap
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        r2 = cyc;
        repeat (12) tick(1'b0, 1'b0);
        chk("double_count", ev_cyc.size(), 1);
        chk("double_type", first_type(), 2);
        chk("double_latency", first_cyc() - r2, 8);
        chk("double_busy", int'(busy), 0);

        // Triple click: event right after the third press, fourth press ignored
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        p3 = cyc;
        chk("triple_valid", int'(event_valid), 1);
        chk("triple_type",  int'(event_type), 3);
        tick(1'b1, 1'b1);
        chk("triple_4th_ignored", int'(event_valid), 0);
        chk("triple_busy_wait", int'(busy), 1);
        repeat (2) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("triple_busy_release", int'(busy), 0);
        repeat (20) tick(1'b0, 1'b0);
        chk("triple_count", ev_cyc.size(), 1);
        chk("triple_latency", first_cyc() - p3, 0);

        // Long press held 20 cycles
        clear_log();
        tick(1'b1, 1'b1);
        e0 = cyc;
        repeat (15) tick(1'b0, 1'b1);
        chk("long_no_early", int'(event_valid), 0);
        tick(1'b0, 1'b1);
        chk("long_valid", int'(event_valid), 1);
        chk("long_type",  int'(event_type), 4);
        repeat (4) tick(1'b0, 1'b1);
        chk("long_busy_hold", int'(busy), 1);
        tick(1'b0, 1'b0);
        chk("long_busy_release", int'(busy), 0);
        repeat (12) tick(1'b0, 1'b0);
        chk("long_count", ev_cyc.size(), 1);
        chk("long_latency", first_cyc() - e0, 16);

        // Press on the exact window-expiry cycle continues the gesture
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        repeat (7) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("edge_no_event", int'(event_valid), 0);
        chk("edge_busy", int'(busy), 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        r2 = cyc;
        repeat (12) tick(1'b0, 1'b0);
        chk("edge_count", ev_cyc.size(), 1);
        chk("edge_type", first_type(), 2);
        chk("edge_latency", first_cyc() - r2, 8);

        // Reset mid-HELD discards the gesture
        clear_log();
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1);
        chk("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(event_valid), 0);
        chk("midrst_type",  int'(event_type), 0);
        chk("midrst_busy",  int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
        chk("midrst_level_ignored", int'(busy), 0);
        tick(1'b0, 1'b0);
        repeat (20) tick(1'b0, 1'b0);
        chk("midrst_count", ev_cyc.size(), 0);
        chk("midrst_busy_after", int'(busy), 0);

        chk("back_to_back", b2b, 0);
        chk("idle_type_zero", bad_idle, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
